// File: rtl/prim_pad_wrapper_pkg.sv
// Pad wrapper types shared by pad-side blocks.
// Defines the per-pad attribute bundle and its field widths.
package prim_pad_wrapper_pkg;

  localparam int DriveStrDw = 4;
  localparam int SlewRateDw = 2;

  typedef struct packed {
    logic [DriveStrDw-1:0] drive_strength;
    logic [SlewRateDw-1:0] slew_rate;
    logic                  od_en;
    logic                  schmitt_en;
    logic                  keeper_en;
    logic                  pull_select;
    logic                  pull_en;
    logic                  virt_od_en;
    logic                  invert;
  } pad_attr_t;

  localparam int AttrDw = $bits(pad_attr_t);

endpackage

// File: rtl/prim_pad_attr_readback_if.sv
// Valid/ready beat stream carrying pad attribute readback data.
// The producer drives data/valid/last; the consumer drives ready.
interface prim_pad_attr_readback_if #(
  parameter int OutW = 4
);
  logic [OutW-1:0] data;
  logic            valid;
  logic            ready;
  logic            last;

  modport master (
    output data,
    output valid,
    output last,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  last,
    output ready
  );
endinterface

// File: rtl/prim_pad_attr_readback.sv
// Snapshots all pad attributes and streams them out LSB-first in OutW beats.
// Define PAD_ATTR_READBACK_PARITY_EN to append a parity beat to each stream.
module prim_pad_attr_readback
  import prim_pad_wrapper_pkg::*;
#(
  parameter int NumPads = 4,
  parameter int OutW    = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic [NumPads*AttrDw-1:0] attr_i,
  output logic                      busy_o,
  output logic [OutW-1:0]           data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      last_o,
  output logic                      done_o
);

  localparam int BeatsPerPad = (AttrDw + OutW - 1) / OutW;
  localparam int PadW        = BeatsPerPad * OutW;
  localparam int BeatW       = (BeatsPerPad > 1) ? $clog2(BeatsPerPad) : 1;
  localparam int PadCntW     = (NumPads > 1) ? $clog2(NumPads) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef PAD_ATTR_READBACK_PARITY_EN
    PAR   = 2'd2,
`endif
    DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  pad_attr_t [NumPads-1:0] snap_q;
  logic [BeatW-1:0]        beat_q;
  logic [PadCntW-1:0]      pad_q;

  logic              last_beat;
  logic              last_pad;
  logic              xfer;
  logic [AttrDw-1:0] cur_attr;
  logic [PadW-1:0]   cur_pad;
  logic [OutW-1:0]   beat_data;

  assign last_beat = (beat_q == BeatW'(BeatsPerPad - 1));
  assign last_pad  = (pad_q == PadCntW'(NumPads - 1));
  assign xfer      = valid_o & ready_i;

  // Pad image is zero-extended so the top beat's spare bits read as 0.
  assign cur_attr  = snap_q[pad_q];
  assign cur_pad   = PadW'(cur_attr);
  assign beat_data = cur_pad[int'(beat_q)*OutW +: OutW];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_i) state_d = SHIFT;
      end
      SHIFT: begin
        if (xfer && last_beat && last_pad) begin
`ifdef PAD_ATTR_READBACK_PARITY_EN
          state_d = PAR;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef PAD_ATTR_READBACK_PARITY_EN
      PAR: begin
        if (xfer) state_d = DONE;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snap_q <= '0;
      beat_q <= '0;
      pad_q  <= '0;
    end else if (state_q == IDLE && req_i) begin
      snap_q <= attr_i;
      beat_q <= '0;
      pad_q  <= '0;
    end else if (state_q == SHIFT && xfer) begin
      if (last_beat) begin
        beat_q <= '0;
        pad_q  <= last_pad ? '0 : pad_q + 1'b1;
      end else begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  always_comb begin
    busy_o  = (state_q != IDLE);
    valid_o = 1'b0;
    data_o  = '0;
    last_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      SHIFT: begin
        valid_o = 1'b1;
        data_o  = beat_data;
`ifndef PAD_ATTR_READBACK_PARITY_EN
        last_o  = last_beat & last_pad;
`endif
      end
`ifdef PAD_ATTR_READBACK_PARITY_EN
      PAR: begin
        valid_o = 1'b1;
        data_o  = OutW'(^snap_q);
        last_o  = 1'b1;
      end
`endif
      DONE: done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prim_pad_attr_readback.sv
// Randomized bench for prim_pad_attr_readback (NumPads=2, OutW=4).
// Expected beats come from a bit-level model of the readback rules.
module tb_prim_pad_attr_readback;
  import prim_pad_wrapper_pkg::*;

  localparam int NP   = 2;
  localparam int OW   = 4;
  localparam int BPP  = (AttrDw + OW - 1) / OW;
  localparam int AW   = NP * AttrDw;

  logic          clk = 0;
  logic          rst = 1;
  logic          req = 0;
  logic [AW-1:0] attr = '0;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  logic [OW-1:0] exp_q[$];

  prim_pad_attr_readback_if #(.OutW(OW)) bus ();

  prim_pad_attr_readback #(
    .NumPads (NP),
    .OutW    (OW)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .attr_i  (attr),
    .busy_o  (busy),
    .data_o  (bus.data),
    .valid_o (bus.valid),
    .ready_i (bus.ready),
    .last_o  (bus.last),
    .done_o  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pad p, beat b, bit i maps to pad-relative bit b*OW+i; past AttrDw reads 0.
  task automatic build_exp(input logic [AW-1:0] a);
    logic [OW-1:0] v;
    int idx;
    exp_q.delete();
    for (int p = 0; p < NP; p++) begin
      for (int b = 0; b < BPP; b++) begin
        v = '0;
        for (int i = 0; i < OW; i++) begin
          idx = b * OW + i;
          if (idx < AttrDw) v[i] = a[p*AttrDw + idx];
        end
        exp_q.push_back(v);
      end
    end
`ifdef PAD_ATTR_READBACK_PARITY_EN
    v = '0;
    v[0] = ^a;
    exp_q.push_back(v);
`endif
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, bus.valid, 0);
    chk({tag, "_last"}, bus.last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_data"}, bus.data, 0);
  endtask

  // mode 0: ready always 1, 1: 3-cycle stall on beat 2, 2: random ready
  task automatic stream(input logic [AW-1:0] a, input int mode,
                        input bit chg, input bit poke, input int abort_at);
    int n;
    int cyc;
    int stall;
    logic r;
    logic pv;
    logic pr;
    logic [OW-1:0] pd;
    logic pl;
    build_exp(a);
    attr = a;
    req = 1;
    step();
    req = 0;
    chk("lat_valid", bus.valid, 1);
    if (chg) attr = '1;
    n = 0;
    cyc = 0;
    stall = 0;
    pv = 0;
    pr = 1;
    pd = '0;
    pl = 0;
    while (n < exp_q.size() && cyc < 200) begin
      case (mode)
        0: r = 1'b1;
        1: r = !(n == 1 && stall < 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.ready = r;
      if (abort_at >= 0 && n == abort_at) begin
        rst = 1;
        step();
        rst = 0;
        check_idle("abort");
        for (int k = 0; k < 4; k++) begin
          step();
          chk("abort_nodone", done, 0);
        end
        return;
      end
      chk("valid", bus.valid, 1);
      chk("data", bus.data, exp_q[n]);
      chk("last", bus.last, (n == exp_q.size() - 1));
      chk("done_mid", done, 0);
      if (pv && !pr) begin
        chk("hold_data", bus.data, pd);
        chk("hold_last", bus.last, pl);
      end
      if (mode == 1 && n == 1 && !r) stall++;
      pv = bus.valid;
      pr = r;
      pd = bus.data;
      pl = bus.last;
      if (bus.valid && r) n++;
      req = poke && ($urandom_range(0, 2) == 0);
      step();
      cyc++;
    end
    req = 0;
    bus.ready = 1'($urandom_range(0, 1));
    chk("timeout", (cyc < 200), 1);
    if (mode == 0) chk("b2b_cycles", cyc, exp_q.size());
    if (mode == 1) chk("stall_cycles", stall, 3);
    chk("done", done, 1);
    chk("done_valid", bus.valid, 0);
    chk("done_busy", busy, 1);
    step();
    chk("done_pulse", done, 0);
    chk("end_busy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_idle", busy, 0);
    end
  endtask

  logic [AW-1:0] ref_a;

  initial begin
    bus.ready = 1;
    ref_a = {13'h0123, 13'h1ABC};
    step();
    step();
    rst = 0;
    check_idle("reset");
    stream(ref_a, 0, 0, 0, -1);
    stream(ref_a, 1, 0, 0, -1);
    stream(ref_a, 0, 1, 0, -1);
    stream(ref_a, 0, 0, 0, 4);
    stream(ref_a, 0, 0, 0, -1);
    stream(ref_a, 2, 0, 1, -1);
    for (int t = 0; t < 12; t++) begin
      stream(AW'($urandom()), 2, t[0], t[1], -1);
    end
    stream(AW'($urandom()), 2, 0, 0, 3);
    stream('1, 0, 0, 0, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
